// File: rtl/logic_axi4_stream_upsizer_pkg.sv
// Shared definitions for the narrow-to-wide AXI4-Stream upsizer.
//  - calc_ratio / calc_idx_width: lane count and lane-index width from the bus sizes.
//  - state_e: accumulator state, EMPTY (no lanes held) or FILLING (some lanes held).
//  - lane_mask: bit l set for every lane l <= idx.
package logic_axi4_stream_upsizer_pkg;

  // Upper bound on lanes per wide beat; lane_mask is sized to this.
  localparam int unsigned MAX_LANES = 64;

  typedef enum logic [0:0] {EMPTY, FILLING} state_e;

  function automatic int unsigned calc_ratio(int unsigned rx_bytes, int unsigned tx_bytes);
    return (rx_bytes == 0) ? 1 : tx_bytes / rx_bytes;
  endfunction

  function automatic int unsigned calc_idx_width(int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic logic [MAX_LANES-1:0] lane_mask(int unsigned idx);
    logic [MAX_LANES-1:0] mask;
    for (int unsigned l = 0; l < MAX_LANES; l++) begin
      mask[l] = (l <= idx);
    end
    return mask;
  endfunction

endpackage

// File: rtl/logic_axi4_stream_upsizer_if.sv
// AXI4-Stream bundle used on both sides of the upsizer.
//  tx / master : source view (drives payload and tvalid, samples tready)
//  rx / slave  : sink view (samples payload and tvalid, drives tready)
interface logic_axi4_stream_if
  import logic_axi4_stream_upsizer_pkg::*;
#(
  parameter int unsigned TDATA_BYTES = 1,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 1
);
  logic                     tvalid;
  logic                     tready;
  logic [8*TDATA_BYTES-1:0] tdata;
  logic [TDATA_BYTES-1:0]   tkeep;
  logic [TDATA_BYTES-1:0]   tstrb;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic                     tlast;
  logic [TID_WIDTH-1:0]     tid;
  logic [TDEST_WIDTH-1:0]   tdest;

  modport tx (output tvalid, tdata, tkeep, tstrb, tuser, tlast, tid, tdest, input tready);
  modport rx (input tvalid, tdata, tkeep, tstrb, tuser, tlast, tid, tdest, output tready);
  modport master (output tvalid, tdata, tkeep, tstrb, tuser, tlast, tid, tdest, input tready);
  modport slave (input tvalid, tdata, tkeep, tstrb, tuser, tlast, tid, tdest, output tready);
endinterface

// File: rtl/logic_axi4_stream_upsizer_main.sv
// Accumulator, lane-index FSM and registered tx stage of the upsizer.
//  aclk/reset : clock, synchronous active-high reset
//  rx_*       : narrow sink (rx_tready is combinational from tx state only)
//  tx_*       : wide source, all payload registered
module logic_axi4_stream_upsizer_main
  import logic_axi4_stream_upsizer_pkg::*;
#(
  parameter int unsigned RX_TDATA_BYTES = 1,
  parameter int unsigned TX_TDATA_BYTES = 4,
  parameter int unsigned RX_TUSER_WIDTH = 1,
  parameter int unsigned TX_TUSER_WIDTH = 4,
  parameter int unsigned TDEST_WIDTH    = 1,
  parameter int unsigned TID_WIDTH      = 1,
  parameter bit          USE_TLAST      = 1'b1,
  parameter bit          USE_TKEEP      = 1'b1,
  parameter bit          USE_TSTRB      = 1'b1
) (
  input  logic                        aclk,
  input  logic                        reset,
  input  logic                        rx_tvalid,
  output logic                        rx_tready,
  input  logic [8*RX_TDATA_BYTES-1:0] rx_tdata,
  input  logic [RX_TDATA_BYTES-1:0]   rx_tkeep,
  input  logic [RX_TDATA_BYTES-1:0]   rx_tstrb,
  input  logic [RX_TUSER_WIDTH-1:0]   rx_tuser,
  input  logic                        rx_tlast,
  input  logic [TID_WIDTH-1:0]        rx_tid,
  input  logic [TDEST_WIDTH-1:0]      rx_tdest,
  output logic                        tx_tvalid,
  input  logic                        tx_tready,
  output logic [8*TX_TDATA_BYTES-1:0] tx_tdata,
  output logic [TX_TDATA_BYTES-1:0]   tx_tkeep,
  output logic [TX_TDATA_BYTES-1:0]   tx_tstrb,
  output logic [TX_TUSER_WIDTH-1:0]   tx_tuser,
  output logic                        tx_tlast,
  output logic [TID_WIDTH-1:0]        tx_tid,
  output logic [TDEST_WIDTH-1:0]      tx_tdest
);
  localparam int unsigned RATIO     = calc_ratio(RX_TDATA_BYTES, TX_TDATA_BYTES);
  localparam int unsigned IDX_WIDTH = calc_idx_width(RATIO);
  localparam int unsigned LANE_BITS = 8 * RX_TDATA_BYTES;

  typedef logic [IDX_WIDTH-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(RATIO - 1);

  state_e                      state;
  idx_t                        idx;
  logic [8*TX_TDATA_BYTES-1:0] acc_data, merge_data, out_data;
  logic [TX_TDATA_BYTES-1:0]   acc_keep, merge_keep, out_keep;
  logic [TX_TDATA_BYTES-1:0]   acc_strb, merge_strb, out_strb;
  logic [TX_TUSER_WIDTH-1:0]   acc_user, merge_user;
  logic [TID_WIDTH-1:0]        acc_id, first_id;
  logic [TDEST_WIDTH-1:0]      acc_dest, first_dest;
  logic [MAX_LANES-1:0]        mask;
  logic                        accept, complete;

  assign rx_tready = !tx_tvalid || tx_tready;
  assign accept    = rx_tvalid && rx_tready;
  assign complete  = accept && ((idx == LAST_IDX) || (USE_TLAST && rx_tlast));

  // tid/tdest belong to the first lane of the wide beat.
  assign first_id   = (state == EMPTY) ? rx_tid : acc_id;
  assign first_dest = (state == EMPTY) ? rx_tdest : acc_dest;

  assign tx_tkeep = USE_TKEEP ? out_keep : '1;
  assign tx_tstrb = USE_TSTRB ? out_strb : '1;
  assign tx_tdata = out_data;

  // Held lanes below idx, the incoming lane at idx, zero above idx.
  always_comb begin
    mask       = lane_mask(32'(idx));
    merge_data = '0;
    merge_keep = '0;
    merge_strb = '0;
    merge_user = '0;
    for (int unsigned l = 0; l < RATIO; l++) begin
      if (idx_t'(l) == idx) begin
        merge_data[l*LANE_BITS +: LANE_BITS]           = rx_tdata;
        merge_keep[l*RX_TDATA_BYTES +: RX_TDATA_BYTES] = USE_TKEEP ? rx_tkeep : '1;
        merge_strb[l*RX_TDATA_BYTES +: RX_TDATA_BYTES] = USE_TSTRB ? rx_tstrb : '1;
        merge_user[l*RX_TUSER_WIDTH +: RX_TUSER_WIDTH] = rx_tuser;
      end else if (mask[l]) begin
        merge_data[l*LANE_BITS +: LANE_BITS] = acc_data[l*LANE_BITS +: LANE_BITS];
        merge_keep[l*RX_TDATA_BYTES +: RX_TDATA_BYTES] =
            acc_keep[l*RX_TDATA_BYTES +: RX_TDATA_BYTES];
        merge_strb[l*RX_TDATA_BYTES +: RX_TDATA_BYTES] =
            acc_strb[l*RX_TDATA_BYTES +: RX_TDATA_BYTES];
        merge_user[l*RX_TUSER_WIDTH +: RX_TUSER_WIDTH] =
            acc_user[l*RX_TUSER_WIDTH +: RX_TUSER_WIDTH];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state     <= EMPTY;
      idx       <= '0;
      acc_data  <= '0;
      acc_keep  <= '0;
      acc_strb  <= '0;
      acc_user  <= '0;
      acc_id    <= '0;
      acc_dest  <= '0;
      tx_tvalid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_strb  <= '0;
      tx_tuser  <= '0;
      tx_tlast  <= 1'b0;
      tx_tid    <= '0;
      tx_tdest  <= '0;
    end else if (complete) begin
      // rx_tready guarantees the previous beat is gone or leaving this cycle.
      tx_tvalid <= 1'b1;
      out_data  <= merge_data;
      out_keep  <= merge_keep;
      out_strb  <= merge_strb;
      tx_tuser  <= merge_user;
      tx_tlast  <= USE_TLAST && rx_tlast;
      tx_tid    <= first_id;
      tx_tdest  <= first_dest;
      state     <= EMPTY;
      idx       <= '0;
      acc_data  <= '0;
      acc_keep  <= '0;
      acc_strb  <= '0;
      acc_user  <= '0;
    end else begin
      if (tx_tready) tx_tvalid <= 1'b0;
      if (accept) begin
        acc_data <= merge_data;
        acc_keep <= merge_keep;
        acc_strb <= merge_strb;
        acc_user <= merge_user;
        acc_id   <= first_id;
        acc_dest <= first_dest;
        idx      <= idx + idx_t'(1);
        state    <= FILLING;
      end
    end
  end

endmodule

// File: rtl/logic_axi4_stream_upsizer.sv
// Packs RATIO = TX_TDATA_BYTES/RX_TDATA_BYTES narrow AXI4-Stream beats into one wide beat,
// first beat in lane 0; tlast closes a partial beat early with the unfilled lanes zeroed.
//  aclk  : clock, rising edge
//  reset : synchronous, active-high
//  rx    : narrow sink (logic_axi4_stream_if.rx)
//  tx    : wide source (logic_axi4_stream_if.tx)
module logic_axi4_stream_upsizer
  import logic_axi4_stream_upsizer_pkg::*;
#(
  parameter int unsigned RX_TDATA_BYTES = 1,
  parameter int unsigned TX_TDATA_BYTES = 4,
  parameter int unsigned RX_TUSER_WIDTH = 1,
  parameter int unsigned TX_TUSER_WIDTH =
      RX_TUSER_WIDTH * calc_ratio(RX_TDATA_BYTES, TX_TDATA_BYTES),
  parameter int unsigned TDEST_WIDTH    = 1,
  parameter int unsigned TID_WIDTH      = 1,
  parameter bit          USE_TLAST      = 1'b1,
  parameter bit          USE_TKEEP      = 1'b1,
  parameter bit          USE_TSTRB      = 1'b1
) (
  input logic               aclk,
  input logic               reset,
  logic_axi4_stream_if.rx   rx,
  logic_axi4_stream_if.tx   tx
);
  localparam int unsigned RATIO = calc_ratio(RX_TDATA_BYTES, TX_TDATA_BYTES);

  if (RX_TDATA_BYTES == 0 || (TX_TDATA_BYTES % RX_TDATA_BYTES) != 0) begin : g_bad_bytes
    $error("TX_TDATA_BYTES must be a non-zero multiple of RX_TDATA_BYTES");
  end
  if (TX_TUSER_WIDTH != RX_TUSER_WIDTH * RATIO) begin : g_bad_user
    $error("TX_TUSER_WIDTH must equal RX_TUSER_WIDTH * RATIO");
  end
  if (RATIO > MAX_LANES) begin : g_bad_lanes
    $error("RATIO exceeds MAX_LANES");
  end

  logic_axi4_stream_upsizer_main #(
    .RX_TDATA_BYTES (RX_TDATA_BYTES),
    .TX_TDATA_BYTES (TX_TDATA_BYTES),
    .RX_TUSER_WIDTH (RX_TUSER_WIDTH),
    .TX_TUSER_WIDTH (TX_TUSER_WIDTH),
    .TDEST_WIDTH    (TDEST_WIDTH),
    .TID_WIDTH      (TID_WIDTH),
    .USE_TLAST      (USE_TLAST),
    .USE_TKEEP      (USE_TKEEP),
    .USE_TSTRB      (USE_TSTRB)
  ) u_main (
    .aclk      (aclk),
    .reset     (reset),
    .rx_tvalid (rx.tvalid),
    .rx_tready (rx.tready),
    .rx_tdata  (rx.tdata),
    .rx_tkeep  (rx.tkeep),
    .rx_tstrb  (rx.tstrb),
    .rx_tuser  (rx.tuser),
    .rx_tlast  (rx.tlast),
    .rx_tid    (rx.tid),
    .rx_tdest  (rx.tdest),
    .tx_tvalid (tx.tvalid),
    .tx_tready (tx.tready),
    .tx_tdata  (tx.tdata),
    .tx_tkeep  (tx.tkeep),
    .tx_tstrb  (tx.tstrb),
    .tx_tuser  (tx.tuser),
    .tx_tlast  (tx.tlast),
    .tx_tid    (tx.tid),
    .tx_tdest  (tx.tdest)
  );

endmodule

// File: tb/tb_logic_axi4_stream_upsizer.sv
// Directed and randomized bench for the 1->4 byte upsizer plus a 2->2 byte (RATIO=1) instance.
module tb_logic_axi4_stream_upsizer;

  logic aclk = 1'b0;
  logic reset = 1'b1;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic_axi4_stream_if #(.TDATA_BYTES(1), .TUSER_WIDTH(1), .TDEST_WIDTH(4), .TID_WIDTH(4)) rx_if ();
  logic_axi4_stream_if #(.TDATA_BYTES(4), .TUSER_WIDTH(4), .TDEST_WIDTH(4), .TID_WIDTH(4)) tx_if ();
  logic_axi4_stream_if #(.TDATA_BYTES(2), .TUSER_WIDTH(1), .TDEST_WIDTH(4), .TID_WIDTH(4)) r1_rx ();
  logic_axi4_stream_if #(.TDATA_BYTES(2), .TUSER_WIDTH(1), .TDEST_WIDTH(4), .TID_WIDTH(4)) r1_tx ();

  logic_axi4_stream_upsizer #(
    .RX_TDATA_BYTES (1),
    .TX_TDATA_BYTES (4),
    .RX_TUSER_WIDTH (1),
    .TX_TUSER_WIDTH (4),
    .TDEST_WIDTH    (4),
    .TID_WIDTH      (4)
  ) dut (
    .aclk  (aclk),
    .reset (reset),
    .rx    (rx_if),
    .tx    (tx_if)
  );

  logic_axi4_stream_upsizer #(
    .RX_TDATA_BYTES (2),
    .TX_TDATA_BYTES (2),
    .RX_TUSER_WIDTH (1),
    .TX_TUSER_WIDTH (1),
    .TDEST_WIDTH    (4),
    .TID_WIDTH      (4)
  ) dut_r1 (
    .aclk  (aclk),
    .reset (reset),
    .rx    (r1_rx),
    .tx    (r1_tx)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: collect accepted narrow beats; a packet end or a 4th byte closes a wide beat.
  typedef struct packed {
    logic [7:0] data;
    logic       keep;
    logic       strb;
    logic       user;
    logic [3:0] id;
    logic [3:0] dest;
  } narrow_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [3:0]  strb;
    logic [3:0]  user;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
  } wide_t;

  narrow_t     pend[$];
  wide_t       exp_q[$];
  int          hs_cycles[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge aclk) begin
    if (reset) begin
      pend.delete();
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", 64'(tx_if.tvalid), 64'(1));
        chk("stall_data_held", 64'(tx_if.tdata), 64'(prev_data));
      end
      prev_stall = tx_if.tvalid && !tx_if.tready;
      prev_data  = tx_if.tdata;
      if (tx_if.tvalid && tx_if.tready) begin
        hs_cycles.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_tx_beat", 64'(tx_if.tdata), 64'hDEAD_0000_0000);
        end else begin
          wide_t e;
          e = exp_q.pop_front();
          chk("sb_tdata", 64'(tx_if.tdata), 64'(e.data));
          chk("sb_tkeep", 64'(tx_if.tkeep), 64'(e.keep));
          chk("sb_tstrb", 64'(tx_if.tstrb), 64'(e.strb));
          chk("sb_tuser", 64'(tx_if.tuser), 64'(e.user));
          chk("sb_tlast", 64'(tx_if.tlast), 64'(e.last));
          chk("sb_tid", 64'(tx_if.tid), 64'(e.id));
          chk("sb_tdest", 64'(tx_if.tdest), 64'(e.dest));
        end
      end
      if (rx_if.tvalid && rx_if.tready) begin
        narrow_t n;
        n.data = rx_if.tdata;
        n.keep = rx_if.tkeep[0];
        n.strb = rx_if.tstrb[0];
        n.user = rx_if.tuser[0];
        n.id   = rx_if.tid;
        n.dest = rx_if.tdest;
        pend.push_back(n);
        if (pend.size() == 4 || rx_if.tlast) begin
          wide_t w;
          w = '0;
          for (int i = 0; i < pend.size(); i++) begin
            w.data = w.data | (32'(pend[i].data) << (8 * i));
            w.keep = w.keep | (4'(pend[i].keep) << i);
            w.strb = w.strb | (4'(pend[i].strb) << i);
            w.user = w.user | (4'(pend[i].user) << i);
          end
          w.last = rx_if.tlast;
          w.id   = pend[0].id;
          w.dest = pend[0].dest;
          exp_q.push_back(w);
          pend.delete();
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic k, input logic s, input logic u,
                      input logic l, input logic [3:0] id, input logic [3:0] dest);
    int waited = 0;
    rx_if.tvalid = 1'b1;
    rx_if.tdata  = d;
    rx_if.tkeep  = k;
    rx_if.tstrb  = s;
    rx_if.tuser  = u;
    rx_if.tlast  = l;
    rx_if.tid    = id;
    rx_if.tdest  = dest;
    @(negedge aclk);
    while (!rx_if.tready && waited < 100) begin
      waited++;
      @(negedge aclk);
    end
    if (!rx_if.tready) chk("rx_accept_timeout", 64'(waited), 64'(0));
    @(posedge aclk);
    #1;
    rx_if.tvalid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  logic rand_done;

  initial begin
    rx_if.tvalid = 1'b0;
    rx_if.tdata  = '0;
    rx_if.tkeep  = '0;
    rx_if.tstrb  = '0;
    rx_if.tuser  = '0;
    rx_if.tlast  = 1'b0;
    rx_if.tid    = '0;
    rx_if.tdest  = '0;
    tx_if.tready = 1'b1;
    r1_rx.tvalid = 1'b0;
    r1_rx.tdata  = '0;
    r1_rx.tkeep  = '0;
    r1_rx.tstrb  = '0;
    r1_rx.tuser  = '0;
    r1_rx.tlast  = 1'b0;
    r1_rx.tid    = '0;
    r1_rx.tdest  = '0;
    r1_tx.tready = 1'b1;

    // Reset state
    repeat (2) @(negedge aclk);
    chk("reset_tvalid", 64'(tx_if.tvalid), 64'(0));
    chk("reset_tdata", 64'(tx_if.tdata), 64'(0));
    chk("reset_tkeep", 64'(tx_if.tkeep), 64'(0));
    chk("reset_tlast", 64'(tx_if.tlast), 64'(0));
    chk("reset_r1_tvalid", 64'(r1_tx.tvalid), 64'(0));
    @(posedge aclk);
    #1;
    reset = 1'b0;
    @(negedge aclk);
    chk("rx_tready_after_reset", 64'(rx_if.tready), 64'(1));
    @(posedge aclk);
    #1;

    // 1: full beat with tlast on lane 3
    send(8'h11, 1, 1, 0, 0, 4'h1, 4'h2);
    send(8'h22, 1, 1, 0, 0, 4'h1, 4'h2);
    send(8'h33, 1, 1, 0, 0, 4'h1, 4'h2);
    send(8'h44, 1, 1, 0, 1, 4'h1, 4'h2);
    @(negedge aclk);
    chk("t1_tvalid", 64'(tx_if.tvalid), 64'(1));
    chk("t1_tdata", 64'(tx_if.tdata), 64'h44332211);
    chk("t1_tkeep", 64'(tx_if.tkeep), 64'hF);
    chk("t1_tlast", 64'(tx_if.tlast), 64'(1));
    @(posedge aclk);
    #1;

    // 2: early tlast, pad lanes zero
    send(8'hAA, 1, 1, 1, 0, 4'h0, 4'h0);
    send(8'hBB, 1, 1, 0, 1, 4'h0, 4'h0);
    @(negedge aclk);
    chk("t2_tdata", 64'(tx_if.tdata), 64'h0000BBAA);
    chk("t2_tkeep", 64'(tx_if.tkeep), 64'h3);
    chk("t2_tstrb", 64'(tx_if.tstrb), 64'h3);
    chk("t2_tuser", 64'(tx_if.tuser), 64'h1);
    chk("t2_tlast", 64'(tx_if.tlast), 64'(1));
    @(posedge aclk);
    #1;

    // 3: backpressure for 5 cycles after the first wide beat appears
    fork
      begin
        for (int i = 1; i <= 8; i++) send(8'(i), 1, 1, 0, (i == 8), 4'h0, 4'h0);
      end
      begin
        int w = 0;
        do begin
          @(posedge aclk);
          #1;
          w++;
        end while (!tx_if.tvalid && w < 50);
        tx_if.tready = 1'b0;
        repeat (5) begin
          @(negedge aclk);
          chk("t3_rx_tready_low", 64'(rx_if.tready), 64'(0));
          chk("t3_tdata_hold", 64'(tx_if.tdata), 64'h04030201);
          @(posedge aclk);
          #1;
        end
        tx_if.tready = 1'b1;
      end
    join
    repeat (4) @(posedge aclk);
    #1;
    chk("t3_drained", 64'(exp_q.size()), 64'(0));

    // 4: reset mid-packet discards the partial beat
    send(8'h11, 1, 1, 0, 0, 4'h0, 4'h0);
    send(8'h22, 1, 1, 0, 0, 4'h0, 4'h0);
    reset = 1'b1;
    @(negedge aclk);
    chk("t4_tvalid_during_reset", 64'(tx_if.tvalid), 64'(0));
    @(posedge aclk);
    #1;
    reset = 1'b0;
    @(negedge aclk);
    chk("t4_tvalid_after_reset", 64'(tx_if.tvalid), 64'(0));
    @(posedge aclk);
    #1;
    send(8'h33, 1, 1, 0, 0, 4'h0, 4'h0);
    send(8'h34, 1, 1, 0, 0, 4'h0, 4'h0);
    send(8'h35, 1, 1, 0, 0, 4'h0, 4'h0);
    send(8'h36, 1, 1, 0, 1, 4'h0, 4'h0);
    @(negedge aclk);
    chk("t4_tvalid", 64'(tx_if.tvalid), 64'(1));
    chk("t4_tdata", 64'(tx_if.tdata), 64'h36353433);
    @(posedge aclk);
    #1;

    // 5: back-to-back, 16 beats -> 4 wide beats every 4 cycles
    hs_cycles.delete();
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1, 1, 0, (i % 4 == 3), 4'h3, 4'h5);
    repeat (3) @(negedge aclk);
    chk("t5_beats", 64'(hs_cycles.size()), 64'(4));
    for (int i = 1; i < hs_cycles.size(); i++) begin
      chk("t5_spacing", 64'(hs_cycles[i] - hs_cycles[i-1]), 64'(4));
    end
    @(posedge aclk);
    #1;

    // Randomized traffic with random tx stalls and rx gaps
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge aclk);
            #1;
          end
          send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               (i == 79) || ($urandom_range(0, 4) == 0), 4'($urandom), 4'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge aclk);
          #1;
          tx_if.tready = ($urandom_range(0, 2) != 0);
        end
        tx_if.tready = 1'b1;
      end
    join
    repeat (5) @(posedge aclk);
    #1;
    chk("rand_drained", 64'(exp_q.size()), 64'(0));
    chk("rand_no_partial", 64'(pend.size()), 64'(0));

    // 6: RATIO=1 instance is a register slice
    r1_rx.tvalid = 1'b1;
    r1_rx.tdata  = 16'hBEEF;
    r1_rx.tkeep  = 2'b01;
    r1_rx.tstrb  = 2'b01;
    r1_rx.tuser  = 1'b1;
    r1_rx.tlast  = 1'b1;
    r1_rx.tid    = 4'h6;
    r1_rx.tdest  = 4'h9;
    @(negedge aclk);
    chk("t6_rx_tready", 64'(r1_rx.tready), 64'(1));
    @(posedge aclk);
    #1;
    r1_rx.tvalid = 1'b0;
    @(negedge aclk);
    chk("t6_tvalid", 64'(r1_tx.tvalid), 64'(1));
    chk("t6_tdata", 64'(r1_tx.tdata), 64'hBEEF);
    chk("t6_tkeep", 64'(r1_tx.tkeep), 64'h1);
    chk("t6_tlast", 64'(r1_tx.tlast), 64'(1));
    chk("t6_tid_tdest", 64'({r1_tx.tid, r1_tx.tdest}), 64'h69);
    @(negedge aclk);
    chk("t6_tvalid_drop", 64'(r1_tx.tvalid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
